// File: rtl/i2c_reg_bank.sv
// I2C target with a bank of NUM_REGS byte registers behind one device address.
// The first written byte selects the register pointer, which auto-increments with wrap.
module i2c_reg_bank #(
  parameter int         FILTER_LEN = 4,
  parameter logic [6:0] DEV_ADDR   = 7'h70,
  parameter int         NUM_REGS   = 8,
  localparam int        PW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  output logic                  scl_o,
  output logic                  scl_t,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_t,
  input  logic [8*NUM_REGS-1:0] data_in,
  input  logic [NUM_REGS-1:0]   data_latch,
  output logic [8*NUM_REGS-1:0] data_out,
  output logic                  wr_valid,
  output logic [PW-1:0]         wr_index,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK, ST_WR_PTR, ST_WR_DATA, ST_RD_DATA, ST_RD_ACK
  } state_t;

  logic [FILTER_LEN-1:0] scl_sh_q, sda_sh_q;
  logic                  scl_f_q, scl_prev_q, sda_f_q, sda_prev_q;

  state_t        state_q;
  logic [7:0]    sh_q;
  logic [3:0]    cnt_q;
  logic          rw_q, ptr_phase_q, ack_drv_q;
  logic [PW-1:0] ptr_q;
  logic          sda_o_q, wr_valid_q, busy_q;
  logic [PW-1:0] wr_index_q;
  logic [7:0]    regs_q [NUM_REGS];

  logic          scl_rise, scl_fall, start_det, stop_det, byte_done, ptr_ok, i2c_we;
  logic [7:0]    rx_byte, rd_byte, rd_next;
  logic [PW-1:0] ptr_inc;

  // A filtered level only moves once the whole sample window agrees.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sh_q   <= '1;
      sda_sh_q   <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sh_q   <= {scl_sh_q[FILTER_LEN-2:0], scl_i};
      sda_sh_q   <= {sda_sh_q[FILTER_LEN-2:0], sda_i};
      if (&scl_sh_q)       scl_f_q <= 1'b1;
      else if (~|scl_sh_q) scl_f_q <= 1'b0;
      if (&sda_sh_q)       sda_f_q <= 1'b1;
      else if (~|sda_sh_q) sda_f_q <= 1'b0;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  assign scl_rise  = scl_f_q & ~scl_prev_q;
  assign scl_fall  = ~scl_f_q & scl_prev_q;
  assign start_det = scl_f_q & sda_prev_q & ~sda_f_q;
  assign stop_det  = scl_f_q & ~sda_prev_q & sda_f_q;
  assign rx_byte   = {sh_q[6:0], sda_f_q};
  assign byte_done = scl_rise && (cnt_q == 4'd0);
  assign ptr_ok    = {1'b0, rx_byte} < 9'(NUM_REGS);
  assign ptr_inc   = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);
  assign rd_byte   = regs_q[ptr_q];
  assign rd_next   = regs_q[ptr_inc];
  assign i2c_we    = (state_q == ST_WR_DATA) && byte_done && !start_det && !stop_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      ptr_phase_q <= 1'b0;
      ack_drv_q   <= 1'b0;
      ptr_q       <= '0;
      sda_o_q     <= 1'b1;
      wr_valid_q  <= 1'b0;
      wr_index_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      if (start_det) begin
        state_q   <= ST_ADDR;
        cnt_q     <= 4'd7;
        sda_o_q   <= 1'b1;
        ack_drv_q <= 1'b0;
      end else if (stop_det) begin
        state_q   <= ST_IDLE;
        sda_o_q   <= 1'b1;
        ack_drv_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_ADDR: if (scl_rise) begin
            sh_q <= rx_byte;
            if (cnt_q == 4'd0) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                rw_q        <= rx_byte[0];
                ptr_phase_q <= ~rx_byte[0];
                busy_q      <= 1'b1;
                state_q     <= ST_ACK;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          // First fall pulls SDA low for the ACK, second fall hands the bus over.
          ST_ACK: if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_o_q   <= 1'b0;
              ack_drv_q <= 1'b1;
            end else begin
              ack_drv_q <= 1'b0;
              cnt_q     <= 4'd7;
              if (rw_q) begin
                sda_o_q <= rd_byte[7];
                sh_q    <= {rd_byte[6:0], 1'b0};
                state_q <= ST_RD_DATA;
              end else begin
                sda_o_q <= 1'b1;
                state_q <= ptr_phase_q ? ST_WR_PTR : ST_WR_DATA;
              end
            end
          end
          ST_WR_PTR: if (scl_rise) begin
            sh_q <= rx_byte;
            if (cnt_q == 4'd0) begin
              if (ptr_ok) begin
                ptr_q       <= rx_byte[PW-1:0];
                ptr_phase_q <= 1'b0;
                state_q     <= ST_ACK;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          ST_WR_DATA: if (scl_rise) begin
            sh_q <= rx_byte;
            if (cnt_q == 4'd0) begin
              wr_valid_q <= 1'b1;
              wr_index_q <= ptr_q;
              ptr_q      <= ptr_inc;
              state_q    <= ST_ACK;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          ST_RD_DATA: if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_o_q <= 1'b1;
              state_q <= ST_RD_ACK;
            end else begin
              sda_o_q <= sh_q[7];
              sh_q    <= {sh_q[6:0], 1'b0};
              cnt_q   <= cnt_q - 4'd1;
            end
          end
          // cnt 8: the next fall drives the MSB of the freshly captured byte.
          ST_RD_ACK: if (scl_rise) begin
            ptr_q <= ptr_inc;
            if (!sda_f_q) begin
              sh_q    <= rd_next;
              cnt_q   <= 4'd8;
              state_q <= ST_RD_DATA;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Fabric loads win over a same-cycle I2C write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (data_latch[k])                         regs_q[k] <= data_in[8*k +: 8];
        else if (i2c_we && (ptr_q == PW'(k)))      regs_q[k] <= rx_byte;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign data_out[8*g +: 8] = regs_q[g];
  end

  assign scl_o    = 1'b1;
  assign scl_t    = 1'b1;
  assign sda_o    = sda_o_q;
  assign sda_t    = sda_o_q;
  assign wr_valid = wr_valid_q;
  assign wr_index = wr_index_q;
  assign busy     = busy_q;

endmodule
